mlu_nibble_seq: RTL and testbench



---
 rtl/mlu_nibble_seq_pkg.sv | 27 ++
 rtl/mlu_nibble_seq.sv | 138 +++++++++++++
 tb/tb_mlu_nibble_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mlu_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial MLU sequencer and its 4-bit slice.
//   - MLU_* opcodes driven onto the slice's opcode input.
//   - Bit positions of the prop/gen/zero flags in the slice output word.
//   - Sequencer state type.
package mlu_nibble_seq_pkg;

  localparam logic [2:0] MLU_NOP0 = 3'd0;
  localparam logic [2:0] MLU_AND  = 3'd1;
  localparam logic [2:0] MLU_OR   = 3'd2;
  localparam logic [2:0] MLU_XOR  = 3'd3;
  localparam logic [2:0] MLU_NOT  = 3'd4;
  localparam logic [2:0] MLU_ADD  = 3'd5;
  localparam logic [2:0] MLU_SUB  = 3'd6;
  localparam logic [2:0] MLU_NOP1 = 3'd7;

  // Slice output word layout: {unused, zero, gen, prop, out[3:0]}
  localparam int unsigned MLU_SLICE_PROP_BIT = 4;
  localparam int unsigned MLU_SLICE_GEN_BIT  = 5;
  localparam int unsigned MLU_SLICE_ZERO_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mlu_seq_state_t;

endpackage

// File: rtl/mlu_nibble_seq.sv
// Nibble-serial MLU sequencer. Runs a WIDTH-bit operation through one external
// combinational 4-bit slice, least-significant nibble first, chaining carry
// through the slice's prop/gen flags and accumulating a zero flag.
//
// Ports:
//   CLK, N_RST          clock, synchronous active-low reset
//   START, OP, A, B     operation request; operands latched when accepted in IDLE
//   BUSY, DONE          BUSY high in RUN and FIN; DONE is a one-cycle pulse in FIN
//   RESULT, CARRY, ZERO result word, final carry (SUB: 1 = no borrow), all-zero flag
//   SLICE_A/B/OP/C_IN   drive to the slice (all zero outside RUN)
//   SLICE_OUT           slice word {unused, zero, gen, prop, out[3:0]}
module mlu_nibble_seq
  import mlu_nibble_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic [3:0]       SLICE_A,
  output logic [3:0]       SLICE_B,
  output logic [2:0]       SLICE_OP,
  output logic             SLICE_C_IN,
  input  logic [7:0]       SLICE_OUT
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("mlu_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  mlu_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  // Bit 7 of the slice word carries nothing for this sequencer.
  logic unused_slice_msb;
  assign unused_slice_msb = SLICE_OUT[7];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    SLICE_A    = '0;
    SLICE_B    = '0;
    SLICE_OP   = '0;
    SLICE_C_IN = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          op_d    = OP;
          a_d     = A;
          b_d     = B;
          idx_d   = '0;
          // SUB is A + ~B + 1, so the chain starts with carry set.
          carry_d = (OP == MLU_SUB);
          zero_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        SLICE_A    = a_q[{idx_q, 2'b00} +: 4];
        SLICE_B    = b_q[{idx_q, 2'b00} +: 4];
        SLICE_OP   = op_q;
        SLICE_C_IN = carry_q;

        result_d[{idx_q, 2'b00} +: 4] = SLICE_OUT[3:0];
        carry_d = SLICE_OUT[MLU_SLICE_GEN_BIT]
                | (SLICE_OUT[MLU_SLICE_PROP_BIT] & carry_q);
        zero_d  = zero_q & SLICE_OUT[MLU_SLICE_ZERO_BIT];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign DONE   = (state_q == FIN);
  assign RESULT = result_q;
  assign CARRY  = carry_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_mlu_nibble_seq.sv
// Self-checking bench for mlu_nibble_seq (WIDTH=32). A behavioural 4-bit slice
// is attached to the SLICE_* ports; expected results come from whole-word
// arithmetic on the operands.
module tb_mlu_nibble_seq;
  import mlu_nibble_seq_pkg::*;

  localparam int unsigned W = 32;

  logic          CLK;
  logic          N_RST;
  logic          START;
  logic [2:0]    OP;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  RESULT;
  logic          CARRY;
  logic          ZERO;
  logic [3:0]    SLICE_A;
  logic [3:0]    SLICE_B;
  logic [2:0]    SLICE_OP;
  logic          SLICE_C_IN;
  logic [7:0]    SLICE_OUT;

  int n_vec = 0;
  int n_err = 0;

  mlu_nibble_seq #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .N_RST      (N_RST),
    .START      (START),
    .OP         (OP),
    .A          (A),
    .B          (B),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .CARRY      (CARRY),
    .ZERO       (ZERO),
    .SLICE_A    (SLICE_A),
    .SLICE_B    (SLICE_B),
    .SLICE_OP   (SLICE_OP),
    .SLICE_C_IN (SLICE_C_IN),
    .SLICE_OUT  (SLICE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural slice: {1, zero, gen, prop, out}. Bit 7 is set to show it is ignored.
  function automatic logic [7:0] slice_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic [3:0] o;
    logic       p;
    logic       g;
    s = '0; o = '0; p = 1'b0; g = 1'b0;
    case (op)
      MLU_ADD: begin s = {1'b0, a} + {1'b0, b};  o = s[3:0] + {3'b000, cin}; g = s[4]; p = (s == 5'd15); end
      MLU_SUB: begin s = {1'b0, a} + {1'b0, ~b}; o = s[3:0] + {3'b000, cin}; g = s[4]; p = (s == 5'd15); end
      MLU_AND: o = a & b;
      MLU_OR:  o = a | b;
      MLU_XOR: o = a ^ b;
      MLU_NOT: o = ~a;
      default: o = '0;
    endcase
    return {1'b1, (o == 4'd0), g, p, o};
  endfunction

  always_comb SLICE_OUT = slice_fn(SLICE_OP, SLICE_A, SLICE_B, SLICE_C_IN);

  // Reference model: {zero, carry, result} from whole-word arithmetic.
  function automatic logic [33:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    r = '0; c = 1'b0;
    case (op)
      MLU_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      MLU_SUB: begin r = a - b; c = (a >= b); end
      MLU_AND: r = a & b;
      MLU_OR:  r = a | b;
      MLU_XOR: r = a ^ b;
      MLU_NOT: r = ~a;
      default: r = '0;
    endcase
    return {(r == 32'd0), c, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency, slice drive, results and the single DONE pulse.
  // Returns at the negedge of the first IDLE cycle after FIN.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] e;
    int          cyc;
    e = ref_op(op, a, b);
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    @(negedge CLK);
    START = 1'b0; OP = 3'($urandom); A = $urandom; B = $urandom;
    cyc = 1;
    chk("busy_run", 64'(BUSY), 64'd1);
    chk("slice_a_nib0", 64'(SLICE_A), 64'(a[3:0]));
    chk("slice_op_run", 64'(SLICE_OP), 64'(op));
    chk("slice_cin_nib0", 64'(SLICE_C_IN), 64'(op == MLU_SUB));
    while (!DONE && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    chk("done_cycle", 64'(cyc), 64'd9);
    chk("result", 64'(RESULT), 64'(e[31:0]));
    chk("carry", 64'(CARRY), 64'(e[32]));
    chk("zero", 64'(ZERO), 64'(e[33]));
    chk("busy_fin", 64'(BUSY), 64'd1);
    @(negedge CLK);
    chk("done_one_cycle", 64'(DONE), 64'd0);
    chk("busy_idle", 64'(BUSY), 64'd0);
    chk("slice_a_idle", 64'(SLICE_A), 64'd0);
  endtask

  initial begin
    logic [31:0] done_mask;
    logic [33:0] e;
    int          pulses;

    N_RST = 1'b0; START = 1'b0; OP = '0; A = '0; B = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_result", 64'(RESULT), 64'd0);
    chk("rst_carry", 64'(CARRY), 64'd0);
    chk("rst_zero", 64'(ZERO), 64'd0);
    chk("rst_slice", 64'({SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN}), 64'd0);
    N_RST = 1'b1;

    // Directed ops
    run_op(MLU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_wrap_const", 64'({ZERO, CARRY, RESULT}), 64'({1'b1, 1'b1, 32'h0}));
    run_op(MLU_SUB, 32'h0000_0005, 32'h0000_0007);
    chk("sub_borrow_const", 64'(RESULT), 64'h0000_0000_FFFF_FFFE);
    run_op(MLU_SUB, 32'h0000_0007, 32'h0000_0005);
    run_op(MLU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("and_const", 64'(RESULT), 64'h0000_0000_00F0_00F0);
    run_op(MLU_NOT, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op(MLU_NOP0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    run_op(MLU_NOP1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    run_op(MLU_OR, 32'h8000_0001, 32'h0000_0000);

    // START held high: ops run back to back, one DONE per 10 cycles,
    // a START seen during FIN is not accepted there.
    @(negedge CLK);
    START = 1'b1; OP = MLU_ADD; A = 32'd1; B = 32'd1;
    done_mask = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (DONE) done_mask[k] = 1'b1;
      if (k == 19) START = 1'b0;
    end
    chk("held_done_mask", 64'(done_mask), 64'((32'd1 << 9) | (32'd1 << 19)));
    chk("held_result", 64'(RESULT), 64'd2);

    // Reset in RUN cycle 4 aborts without DONE and clears outputs.
    @(negedge CLK);
    START = 1'b1; OP = MLU_ADD; A = 32'h1234_5678; B = 32'h1111_1111;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    N_RST = 1'b0;
    @(negedge CLK);
    N_RST = 1'b1;
    chk("abort_outputs", 64'({BUSY, DONE, CARRY, ZERO, RESULT}), 64'd0);
    chk("abort_slice", 64'({SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN}), 64'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op(MLU_ADD, 32'h1234_5678, 32'h1111_1111);
    chk("after_abort_const", 64'(RESULT), 64'h0000_0000_2345_6789);

    // Result holds in IDLE, then back-to-back XOR.
    e = ref_op(MLU_ADD, 32'h0F0F_1234, 32'h7777_0001);
    run_op(MLU_ADD, 32'h0F0F_1234, 32'h7777_0001);
    repeat (4) @(negedge CLK);
    chk("idle_hold_result", 64'({ZERO, CARRY, RESULT}), 64'(e));
    run_op(MLU_XOR, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("xor_const", 64'({CARRY, RESULT}), 64'({1'b0, 32'hFFFF_FFFF}));

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      run_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
